// File: rtl/kfpga_config_pkg.sv
// Shared types and reset levels for the kfpga configuration loader.
package kfpga_config_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SHIFT  = 3'd2,
        VERIFY = 3'd3,
        DONE   = 3'd4
    } state_e;

    // Output levels while the loader sits in reset; the chain is held cleared.
    localparam logic NRESET_RST = 1'b0;
    localparam logic BUSY_RST   = 1'b0;
    localparam logic DONE_RST   = 1'b0;
    localparam logic ERROR_RST  = 1'b0;

endpackage

// File: rtl/config_word_serializer.sv
// Word-to-bit serializer: one holding register drained LSB first, with a
// ready that reopens on the last bit so words can stream without bubbles.
module config_word_serializer #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  stop,
    input  logic                  flush,
    input  logic                  word_valid,
    input  logic [WORD_WIDTH-1:0] word_data,
    output logic                  word_ready,
    output logic                  bit_out,
    output logic                  bit_valid
);

    localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [WORD_WIDTH-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  full_q, full_d;
    logic                  shift;
    logic                  last;
    logic                  accept;

    // Handshake, drain and reload of the holding register.
    always_comb begin
        hold_d     = hold_q;
        idx_d      = idx_q;
        full_d     = full_q;
        shift      = enable && full_q;
        last       = (idx_q == LAST_IDX);
        word_ready = enable && !stop && (!full_q || last);
        accept     = word_valid && word_ready;
        bit_out    = hold_q[idx_q];
        bit_valid  = full_q;

        if (flush) begin
            full_d = 1'b0;
            idx_d  = '0;
        end else if (accept) begin
            hold_d = word_data;
            idx_d  = '0;
            full_d = 1'b1;
        end else if (shift) begin
            if (last) begin
                full_d = 1'b0;
                idx_d  = '0;
            end else begin
                idx_d = idx_q + IDX_ONE;
            end
        end
    end

    // Control state: occupancy flag and bit index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            full_q <= full_d;
            idx_q  <= idx_d;
        end
    end

    // Word payload carries no reset; it is only read while full_q is set.
    always_ff @(posedge clock) begin
        hold_q <= hold_d;
    end

endmodule

// File: rtl/config_loader.sv
// Serial configuration loader for the kfpga tile chain: clear, then shift
// exactly CHAIN_LENGTH bits. Define CONFIG_LOADER_READBACK_EN to add the
// readback check (zero return during shift, recirculating parity verify).
module config_loader
    import kfpga_config_pkg::*;
#(
    parameter int CHAIN_LENGTH = 36,
    parameter int WORD_WIDTH   = 8,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic [WORD_WIDTH-1:0] word_data,
    output logic                  config_out,
    output logic                  config_enable,
    output logic                  config_nreset,
    input  logic                  config_return,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LENGTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CLR_W-1:0] LAST_CLR = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [CLR_W-1:0] CLR_ONE  = CLR_W'(1);

    state_e           state_q, state_d;
    logic [CLR_W-1:0] clr_q, clr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             nreset_q, nreset_d;

    logic ser_ready;
    logic ser_bit;
    logic ser_valid;
    logic shifting;
    logic final_bit;

`ifdef CONFIG_LOADER_READBACK_EN
    logic error_q, error_d;
    logic parity_q, parity_d;
    logic ret_par_q, ret_par_d;
`else
    logic unused_return;
    assign unused_return = config_return;
`endif

    // A bit leaves the holding register on every SHIFT cycle it is occupied;
    // the one that fills the chain also stops intake and drops leftovers.
    assign shifting  = (state_q == SHIFT) && ser_valid;
    assign final_bit = shifting && (cnt_q == LAST_BIT);

    config_word_serializer #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_serializer (
        .clock      (clock),
        .reset      (reset),
        .enable     (state_q == SHIFT),
        .stop       (final_bit),
        .flush      (final_bit),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (ser_ready),
        .bit_out    (ser_bit),
        .bit_valid  (ser_valid)
    );

    // Load sequencing, counters, readback and registered status outputs.
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        cnt_d   = cnt_q;
`ifdef CONFIG_LOADER_READBACK_EN
        error_d   = error_q;
        parity_d  = parity_q;
        ret_par_d = ret_par_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CLEAR;
                    clr_d   = '0;
                    cnt_d   = '0;
`ifdef CONFIG_LOADER_READBACK_EN
                    error_d   = 1'b0;
                    parity_d  = 1'b0;
                    ret_par_d = 1'b0;
`endif
                end
            end
            CLEAR: begin
                if (clr_q == LAST_CLR) begin
                    state_d = SHIFT;
                end else begin
                    clr_d = clr_q + CLR_ONE;
                end
            end
            SHIFT: begin
                if (shifting) begin
                    cnt_d = cnt_q + CNT_ONE;
`ifdef CONFIG_LOADER_READBACK_EN
                    parity_d = parity_q ^ ser_bit;
                    // Chain was just cleared, so anything returning must be 0.
                    if (config_return) begin
                        error_d = 1'b1;
                    end
`endif
                    if (final_bit) begin
`ifdef CONFIG_LOADER_READBACK_EN
                        state_d = VERIFY;
                        cnt_d   = '0;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef CONFIG_LOADER_READBACK_EN
            VERIFY: begin
                ret_par_d = ret_par_q ^ config_return;
                cnt_d     = cnt_q + CNT_ONE;
                if (cnt_q == LAST_BIT) begin
                    if (ret_par_d != parity_q) begin
                        error_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        busy_d   = (state_d == CLEAR) || (state_d == SHIFT) || (state_d == VERIFY);
        done_d   = (state_d == DONE);
        nreset_d = (state_d != CLEAR);
    end

    // Control registers; reset aborts any load in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            clr_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= BUSY_RST;
            done_q   <= DONE_RST;
            nreset_q <= NRESET_RST;
        end else begin
            state_q  <= state_d;
            clr_q    <= clr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            nreset_q <= nreset_d;
        end
    end

`ifdef CONFIG_LOADER_READBACK_EN
    // Readback status and the sent/returned parity accumulators.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            error_q   <= ERROR_RST;
            parity_q  <= 1'b0;
            ret_par_q <= 1'b0;
        end else begin
            error_q   <= error_d;
            parity_q  <= parity_d;
            ret_par_q <= ret_par_d;
        end
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // Chain drive: shift data in SHIFT, recirculate the chain in VERIFY.
    always_comb begin
        config_enable = shifting;
        config_out    = shifting && ser_bit;
`ifdef CONFIG_LOADER_READBACK_EN
        if (state_q == VERIFY) begin
            config_enable = 1'b1;
            config_out    = config_return;
        end
`endif
    end

    assign word_ready    = ser_ready;
    assign busy          = busy_q;
    assign done          = done_q;
    assign config_nreset = nreset_q;

endmodule

// File: tb/tb_config_loader.sv
// Testbench for config_loader with a behavioural model of the 36-bit tile
// chain. Readback scenarios are built when CONFIG_LOADER_READBACK_EN is set.
module tb_config_loader;

    localparam int N = 36;
    localparam logic [N-1:0] IMG = 36'h8040C020A;
`ifdef CONFIG_LOADER_READBACK_EN
    localparam int EXP_EN = 2 * N;
`else
    localparam int EXP_EN = N;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       word_valid;
    logic       word_ready;
    logic [7:0] word_data;
    logic       config_out;
    logic       config_enable;
    logic       config_nreset;
    logic       config_return;
    logic       busy;
    logic       done;
    logic       error;

    logic [N-1:0] chain = '0;
    logic         ret_force;
    logic         flip_pulse;
    logic [7:0]   words [0:5];

    int total = 0;
    int bad   = 0;

    config_loader #(
        .CHAIN_LENGTH (36),
        .WORD_WIDTH   (8),
        .CLEAR_CYCLES (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .word_data     (word_data),
        .config_out    (config_out),
        .config_enable (config_enable),
        .config_nreset (config_nreset),
        .config_return (config_return),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clock = ~clock;

    // Tile chain: clears while nreset is low, shifts config_in at chain[0].
    always @(posedge clock) begin
        if (!config_nreset)
            chain <= '0;
        else if (config_enable)
            chain <= {chain[N-2:0], config_out} ^ (flip_pulse ? 36'd1 : 36'd0);
    end

    assign config_return = ret_force ? 1'b1 : chain[N-1];

    // One load: start pulse, feed words 0x01..0x05 plus a surplus 0xFF,
    // observe handshake/chain activity until done or the cycle budget ends.
    task automatic run_load(input int gap, input bit mid_start, input int abort_at,
                            input bit flip, input bit fret,
                            output int acc, output int en, output int holes,
                            output int nrl_pre, output int nrl_post,
                            output int last_en, output int done_cyc,
                            output bit busy1, output bit tmo);
        int  wi, idle, cyc, gap_run;
        bit  a, sp, seen_en;
        acc = 0; en = 0; holes = 0; nrl_pre = 0; nrl_post = 0;
        last_en = -1; done_cyc = -1; tmo = 1'b0;
        wi = 0; idle = gap; cyc = 0; gap_run = 0; sp = 1'b0; seen_en = 1'b0;
        ret_force = fret;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        busy1 = busy;
        word_valid = 1'b1;
        word_data  = words[0];
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            a = word_valid && word_ready;
            if (!word_valid && word_ready) idle++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (!config_nreset) begin
                if (seen_en) nrl_post++;
                else nrl_pre++;
            end
            if (config_enable) begin
                en++;
                if (seen_en) holes += gap_run;
                gap_run = 0;
                seen_en = 1'b1;
                last_en = cyc;
                flip_pulse = flip && (en == N);
            end else if (seen_en) begin
                gap_run++;
            end
            @(posedge clock); #1;
            cyc++;
            flip_pulse = 1'b0;
            if (abort_at > 0 && en == abort_at) begin
                reset = 1'b1;
                acc = wi;
                start = 1'b0;
                return;
            end
            if (a) begin
                wi++;
                idle = 0;
            end
            if (wi < 6 && idle >= gap) begin
                word_valid = 1'b1;
                word_data  = words[wi];
            end else begin
                word_valid = 1'b0;
            end
            if (mid_start && en == 10 && !sp) begin
                start = 1'b1;
                sp = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        acc = wi;
        if (done_cyc < 0) tmo = 1'b1;
        @(posedge clock); #1;
        word_valid = 1'b0;
        start = 1'b0;
        ret_force = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = 8'h00;
        ret_force = 1'b0; flip_pulse = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total++; if (config_nreset !== 1'b0) begin bad++; $display("FAIL reset_nreset: got %b want 0", config_nreset); end
        total++; if ({busy, done, error, config_enable, config_out, word_ready} !== 6'b0) begin
            bad++; $display("FAIL reset_outputs: got %b want 000000", {busy, done, error, config_enable, config_out, word_ready});
        end
        reset = 1'b0;
        @(posedge clock); #1;
        total++; if (config_nreset !== 1'b1) begin bad++; $display("FAIL idle_nreset: got %b want 1", config_nreset); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int acc, en, holes, nrl_pre, nrl_post, last_en, done_cyc; bit busy1, tmo;
        run_load(0, 1'b0, 0, 1'b0, 1'b0, acc, en, holes, nrl_pre, nrl_post, last_en, done_cyc, busy1, tmo);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL b2b_timeout: done never seen"); end
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL b2b_busy_after_start: got %b want 1", busy1); end
        total++; if (acc != 5) begin bad++; $display("FAIL b2b_words: got %0d want 5", acc); end
        total++; if (en != EXP_EN) begin bad++; $display("FAIL b2b_enables: got %0d want %0d", en, EXP_EN); end
        total++; if (holes != 0) begin bad++; $display("FAIL b2b_holes: got %0d want 0", holes); end
        total++; if (chain !== IMG) begin bad++; $display("FAIL b2b_chain: got %h want %h", chain, IMG); end
        total++; if (done_cyc != last_en + 1) begin bad++; $display("FAIL b2b_done_latency: got %0d want %0d", done_cyc, last_en + 1); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL b2b_error: got %b want 0", error); end
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_done_hold: got done=%b busy=%b want 1 0", done, busy); end
    endtask

    task automatic test_gapped();
        int acc, en, holes, nrl_pre, nrl_post, last_en, done_cyc; bit busy1, tmo;
        run_load(3, 1'b0, 0, 1'b0, 1'b0, acc, en, holes, nrl_pre, nrl_post, last_en, done_cyc, busy1, tmo);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL gap_timeout: done never seen"); end
        total++; if (acc != 5) begin bad++; $display("FAIL gap_words: got %0d want 5", acc); end
        total++; if (en != EXP_EN) begin bad++; $display("FAIL gap_enables: got %0d want %0d", en, EXP_EN); end
        total++; if (holes != 12) begin bad++; $display("FAIL gap_holes: got %0d want 12", holes); end
        total++; if (chain !== IMG) begin bad++; $display("FAIL gap_chain: got %h want %h", chain, IMG); end
    endtask

    task automatic test_clear_and_start_ignored();
        int acc, en, holes, nrl_pre, nrl_post, last_en, done_cyc; bit busy1, tmo;
        run_load(0, 1'b1, 0, 1'b0, 1'b0, acc, en, holes, nrl_pre, nrl_post, last_en, done_cyc, busy1, tmo);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL clr_timeout: done never seen"); end
        total++; if (nrl_pre != 4) begin bad++; $display("FAIL clr_cycles: got %0d want 4", nrl_pre); end
        total++; if (nrl_post != 0) begin bad++; $display("FAIL clr_restart_during_shift: got %0d want 0", nrl_post); end
        total++; if (en != EXP_EN) begin bad++; $display("FAIL clr_enables: got %0d want %0d", en, EXP_EN); end
        total++; if (chain !== IMG) begin bad++; $display("FAIL clr_chain: got %h want %h", chain, IMG); end
    endtask

    task automatic test_reset_midload();
        int acc, en, holes, nrl_pre, nrl_post, last_en, done_cyc; bit busy1, tmo;
        run_load(0, 1'b0, 20, 1'b0, 1'b0, acc, en, holes, nrl_pre, nrl_post, last_en, done_cyc, busy1, tmo);
        #1;
        total++; if (en != 20) begin bad++; $display("FAIL abort_point: got %0d want 20", en); end
        total++; if (config_nreset !== 1'b0) begin bad++; $display("FAIL abort_nreset: got %b want 0", config_nreset); end
        total++; if ({busy, done, error, config_enable, config_out, word_ready} !== 6'b0) begin
            bad++; $display("FAIL abort_outputs: got %b want 000000", {busy, done, error, config_enable, config_out, word_ready});
        end
        word_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        run_load(0, 1'b0, 0, 1'b0, 1'b0, acc, en, holes, nrl_pre, nrl_post, last_en, done_cyc, busy1, tmo);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL reload_timeout: done never seen"); end
        total++; if (acc != 5) begin bad++; $display("FAIL reload_words: got %0d want 5", acc); end
        total++; if (en != EXP_EN) begin bad++; $display("FAIL reload_enables: got %0d want %0d", en, EXP_EN); end
        total++; if (chain !== IMG) begin bad++; $display("FAIL reload_chain: got %h want %h", chain, IMG); end
    endtask

`ifdef CONFIG_LOADER_READBACK_EN
    task automatic test_readback_flip();
        int acc, en, holes, nrl_pre, nrl_post, last_en, done_cyc; bit busy1, tmo;
        run_load(0, 1'b0, 0, 1'b1, 1'b0, acc, en, holes, nrl_pre, nrl_post, last_en, done_cyc, busy1, tmo);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL flip_timeout: done never seen"); end
        total++; if (error !== 1'b1) begin bad++; $display("FAIL flip_error: got %b want 1", error); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL flip_done: got %b want 1", done); end
    endtask

    task automatic test_readback_return_high();
        int acc, en, holes, nrl_pre, nrl_post, last_en, done_cyc; bit busy1, tmo;
        run_load(0, 1'b0, 0, 1'b0, 1'b1, acc, en, holes, nrl_pre, nrl_post, last_en, done_cyc, busy1, tmo);
        total++; if (tmo !== 1'b0) begin bad++; $display("FAIL rethigh_timeout: done never seen"); end
        total++; if (error !== 1'b1) begin bad++; $display("FAIL rethigh_error: got %b want 1", error); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rethigh_done: got %b want 1", done); end
    endtask
`endif

    initial begin
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
        words[3] = 8'h04; words[4] = 8'h05; words[5] = 8'hFF;
        test_reset();
        test_back_to_back();
        test_gapped();
        test_clear_and_start_ignored();
        test_reset_midload();
`ifdef CONFIG_LOADER_READBACK_EN
        test_readback_flip();
        test_readback_return_high();
        test_back_to_back();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/config_loader.md
# config_loader

Bitstream loader that drives the serial configuration chain of the kfpga tile array, such as the chain formed by IO tiles and logic tiles linked config_out to config_in. It accepts configuration words over a valid/ready handshake, clears the chain, then serialises exactly CHAIN_LENGTH bits into it. It sits directly upstream of the first tile's config_in, config_enable and config_nreset pins, and takes the last tile's config_out back as config_return.

## Interface
- CHAIN_LENGTH, 36: total configuration bits in the chain (≥1).
- WORD_WIDTH, 8: bitstream word width (≥1).
- CLEAR_CYCLES, 4: cycles config_nreset is held low before shifting (≥1).

Ports:
- clock  in  1  sole clock; the loader and the chain share it.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle load request.
- word_valid  in  1  word_data is valid.
- word_ready  out  1  loader accepts word_data this cycle.
- word_data  in  WORD_WIDTH  bitstream word; LSB is shifted first.
- config_out  out  1  serial bit to the first tile's config_in.
- config_enable  out  1  chain shift enable.
- config_nreset  out  1  chain clear, active-low.
- config_return  in  1  last tile's config_out.
- busy  out  1  load in progress.
- done  out  1  load finished; held until the next start.
- error  out  1  readback failure; tied 0 when the feature is compiled out.

## Operation
- States: IDLE, CLEAR, SHIFT, VERIFY (feature only), DONE.
- IDLE/DONE + start → CLEAR.
  - Clears done, error, bit counter and parity.
  - start is ignored in CLEAR, SHIFT and VERIFY.
- CLEAR: config_nreset=0 for exactly CLEAR_CYCLES cycles → SHIFT.
- SHIFT:
  - A word is accepted on a cycle with word_valid && word_ready.
  - word_ready=1 in SHIFT when the holding register is empty, or when its last bit is being shifted this cycle. This allows back-to-back words with no bubble.
  - Each cycle the holding register has a bit: config_out = that bit, config_enable=1, bit counter +1.
  - Holding register empty: config_enable=0, and the chain holds.
  - When the counter reaches CHAIN_LENGTH:
    - Any leftover bits of the final word are discarded.
    - word_ready=0.
    - Next state: VERIFY if the feature is compiled in, else DONE.
  - Words needed: ceil(CHAIN_LENGTH/WORD_WIDTH).
  - The first bit shifted ends at chain position CHAIN_LENGTH-1.
- DONE: busy=0, done=1, config_enable=0.
- Bit counter width: $clog2(CHAIN_LENGTH+1). It never wraps.

## Timing
- Reset values:
  - config_nreset=0, so the chain clears while the loader is in reset.
  - All other outputs 0; state IDLE.
- Reset mid-load aborts immediately. The next load restarts from CLEAR.
- All outputs are registered.
- start at cycle t → busy=1 and config_nreset=0 from t+1.
- Word accepted at edge t → its LSB appears on config_out/config_enable at t+1.
- Last bit at cycle t → done=1 at t+1 (no VERIFY), or VERIFY begins at t+1.
- config_return is sampled on every cycle with config_enable=1.

## Configuration
- CONFIG_LOADER_READBACK_EN defined:
  - During SHIFT, every sampled config_return must be 0, because the chain was just cleared. Any 1 sets error.
  - The loader keeps a running XOR parity of the bits sent.
  - VERIFY runs CHAIN_LENGTH cycles with config_enable=1 and config_out=config_return, recirculating the chain so it ends unchanged.
    - The parity of the returned bits is compared against the sent parity. A mismatch sets error.
    - Then → DONE.
  - error holds until the next start.
  - done is asserted regardless of error.
- Undefined:
  - No VERIFY state.
  - config_return is unused.
  - error is tied 0.

## Structure
- Package kfpga_config_pkg holds:
  - the state enum (IDLE, CLEAR, SHIFT, VERIFY, DONE);
  - the reset-level constants.
- Sub-module config_word_serializer holds:
  - the holding register;
  - the bit index;
  - the word_ready/skid logic;
  - outputs bit + bit_valid, with a flush input used at chain end.
- The top level holds the FSM, counters and readback.

## Test plan
- CHAIN_LENGTH=36, WORD_WIDTH=8, words 0x01..0x05 back-to-back → 5 words accepted; exactly 36 config_enable cycles; the last 4 bits of 0x05 are discarded; a bench model of the 36-bit chain equals the expected image; done=1 one cycle after the last shift.
- word_valid gapped by 3 idle cycles between words → config_enable drops during the gaps; final chain contents are identical to the back-to-back case.
- start pulse → config_nreset=0 for exactly 4 cycles before the first config_enable; start pulses during SHIFT are ignored.
- reset asserted after the 20th bit → all outputs return to reset values at once; a fresh start reloads the full 36 bits correctly.
- Readback (feature on), intact chain → error=0 and chain contents unchanged after VERIFY. Bench flips one chain bit before VERIFY → error=1, done=1.
- Readback (feature on), bench drives config_return=1 during SHIFT → error=1.
